// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared types and defaults for the debug-select sweeper and debug tree
package dbg_pkg;

    localparam int DBG_SEL_W        = 8;
    localparam int DBG_DATA_W       = 8;
    // Register depth of the debug-mux tree, counted from the dbgsel flop to a valid din.
    localparam int DBG_TREE_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_FINISH  = 3'd4
    } dbg_sweep_state_t;

    function automatic logic dbg_is_active(input dbg_sweep_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/dbg_sel_sweeper_if.sv
// rtl/dbg_sel_sweeper_if.sv - record stream carrying (select, data) pairs out of the sweeper
interface dbg_sel_sweeper_if #(
    parameter int SEL_W  = 8,
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [SEL_W-1:0]  out_sel;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_sel,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_sel,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/dbg_sample_delay.sv
// rtl/dbg_sample_delay.sv - wait counter that strobes capture once the tree latency has elapsed
module dbg_sample_delay #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic capture
);
    if (LATENCY < 1) begin : g_latency_check
        $error("dbg_sample_delay: LATENCY must be >= 1");
    end

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0] wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (clear) begin
            wcnt_d = '0;
        end else if (run) begin
            wcnt_d = wcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    // Cycle k of WAIT sees wcnt == k, so the capture edge is the LATENCY-th after dbgsel loaded.
    assign capture = run && (wcnt_q == LAST_CNT);

endmodule

// File: rtl/dbg_sel_sweeper.sv
// rtl/dbg_sel_sweeper.sv - sweeps a select range over the debug tree and streams (select, data) records
module dbg_sel_sweeper
    import dbg_pkg::*;
#(
    parameter int SEL_W   = DBG_SEL_W,
    parameter int DATA_W  = DBG_DATA_W,
    parameter int LATENCY = DBG_TREE_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  start_sel,
    input  logic [SEL_W-1:0]  end_sel,
    output logic              busy,
    output logic [SEL_W-1:0]  dbgsel,
    input  logic [DATA_W-1:0] din,
    dbg_sel_sweeper_if.master rec,
    output logic              done,
    output logic              err
);
    if (LATENCY < 1) begin : g_latency_check
        $error("dbg_sel_sweeper: LATENCY must be >= 1");
    end

    dbg_sweep_state_t  state_q, state_d;
    logic [SEL_W-1:0]  cur_q, cur_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic              bad_q, bad_d;
    logic [SEL_W-1:0]  dbgsel_q, dbgsel_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic dly_clear;
    logic dly_run;
    logic dly_capture;

    // Kept outside the FSM process so the capture strobe never feeds back into its own inputs.
    assign dly_clear = (state_q == ST_ISSUE);
    assign dly_run   = (state_q == ST_WAIT);

    dbg_sample_delay #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .clear   (dly_clear),
        .run     (dly_run),
        .capture (dly_capture)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        bad_d       = bad_q;
        dbgsel_d    = dbgsel_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;

        if (abort && dbg_is_active(state_q)) begin
            // A record still waiting for out_ready is dropped; dbgsel keeps its value.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        busy_d = 1'b1;
                        if (start_sel <= end_sel) begin
                            cur_d   = start_sel;
                            last_d  = end_sel;
                            bad_d   = 1'b0;
                            state_d = ST_ISSUE;
                        end else begin
                            bad_d   = 1'b1;
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_ISSUE: begin
                    dbgsel_d = cur_q;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    if (dly_capture) begin
                        out_data_d  = din;
                        out_sel_d   = cur_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (out_valid_q && rec.out_ready) begin
                        out_valid_d = 1'b0;
                        // Compare before incrementing so an all-ones end select never wraps.
                        if (cur_q == last_q) begin
                            state_d = ST_FINISH;
                        end else begin
                            cur_d   = cur_q + SEL_W'(1);
                            state_d = ST_ISSUE;
                        end
                    end
                end
                ST_FINISH: begin
                    done_d  = 1'b1;
                    err_d   = bad_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            bad_q       <= 1'b0;
            dbgsel_q    <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            bad_q       <= bad_d;
            dbgsel_q    <= dbgsel_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign busy          = busy_q;
    assign dbgsel        = dbgsel_q;
    assign done          = done_q;
    assign err           = err_q;
    assign rec.out_valid = out_valid_q;
    assign rec.out_sel   = out_sel_q;
    assign rec.out_data  = out_data_q;

endmodule

// File: tb/tb_dbg_sel_sweeper.sv
// tb/tb_dbg_sel_sweeper.sv - scoreboard bench for dbg_sel_sweeper against a registered debug tree model
module tb_dbg_sel_sweeper;
    import dbg_pkg::*;

    localparam int SW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [SW-1:0] start_sel;
    logic [SW-1:0] end_sel;
    logic          busy;
    logic [SW-1:0] dbgsel;
    logic [DW-1:0] din;
    logic          done;
    logic          err;

    dbg_sel_sweeper_if #(.SEL_W(SW), .DATA_W(DW)) rec_if ();

    dbg_sel_sweeper #(
        .SEL_W   (SW),
        .DATA_W  (DW),
        .LATENCY (DBG_TREE_LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .start_sel (start_sel),
        .end_sel   (end_sel),
        .busy      (busy),
        .dbgsel    (dbgsel),
        .din       (din),
        .rec       (rec_if),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Debug tree: the dbgsel flop is stage one, this register is stage two.
    always @(posedge clk) din <= (dbgsel >= 8'd34 && dbgsel <= 8'd64) ? 8'hA5 : 8'h00;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_count = 0;
    int valid_cycles = 0;
    int prev_cyc = 0;
    bit gap_mode = 1'b0;
    bit have_prev = 1'b0;

    logic [15:0] exp_rec[$];
    logic        exp_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_rec(input logic [7:0] s, input logic [7:0] d);
        exp_rec.push_back({s, d});
    endtask

    // Monitor: pops the scoreboard on every accepted record and every done pulse.
    always @(negedge clk) begin
        logic [15:0] e;
        logic        ed;
        if (rec_if.out_valid) valid_cycles++;
        if (!rst && rec_if.out_valid && rec_if.out_ready) begin
            if (exp_rec.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_record: got sel=%0d data=%0h, none expected",
                         rec_if.out_sel, rec_if.out_data);
            end else begin
                e = exp_rec.pop_front();
                chk("rec_sel", 32'(rec_if.out_sel), 32'(e[15:8]));
                chk("rec_data", 32'(rec_if.out_data), 32'(e[7:0]));
            end
            if (gap_mode) begin
                if (have_prev) chk("rec_gap", 32'(cyc - prev_cyc), 32'd4);
                have_prev = 1'b1;
                prev_cyc  = cyc;
            end
        end
        if (!rst && done) begin
            done_count++;
            chk("busy_at_done", 32'(busy), 32'd0);
            if (exp_done.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 err=%0d, none expected", err);
            end else begin
                ed = exp_done.pop_front();
                chk("done_err", 32'(err), 32'(ed));
            end
        end else if (!rst && err) begin
            total++;
            bad++;
            $display("FAIL err_without_done: got err=1 done=0, want err only with done");
        end
    end

    task automatic go(input logic [7:0] s, input logic [7:0] e);
        @(posedge clk); #1;
        start = 1'b1; start_sel = s; end_sel = e;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n0;
        bit seen;
        n0 = done_count;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (done_count > n0) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (rec_if.out_valid) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_dbgsel"}, 32'(dbgsel), 32'd0);
        chk({tag, "_out_valid"}, 32'(rec_if.out_valid), 32'd0);
        chk({tag, "_out_sel"}, 32'(rec_if.out_sel), 32'd0);
        chk({tag, "_out_data"}, 32'(rec_if.out_data), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int n0;
        int vc0;
        bit seen5;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start_sel = '0; end_sel = '0; rec_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // 33..35 with out_ready high: records four cycles apart
        push_rec(8'd33, 8'h00); push_rec(8'd34, 8'hA5); push_rec(8'd35, 8'hA5);
        exp_done.push_back(1'b0);
        have_prev = 1'b0; gap_mode = 1'b1;
        go(8'd33, 8'd35);
        wait_done("t1_done", 100);
        gap_mode = 1'b0;

        // 64..65 with the first record back-pressured for five cycles
        rec_if.out_ready = 1'b0;
        push_rec(8'd64, 8'hA5); push_rec(8'd65, 8'h00);
        exp_done.push_back(1'b0);
        go(8'd64, 8'd65);
        wait_valid("t2_first_valid", 50);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t2_hold_valid", 32'(rec_if.out_valid), 32'd1);
            chk("t2_hold_sel", 32'(rec_if.out_sel), 32'd64);
            chk("t2_hold_data", 32'(rec_if.out_data), 32'hA5);
        end
        @(posedge clk); #1 rec_if.out_ready = 1'b1;
        wait_done("t2_done", 100);

        // Reversed range: done and err together, no records, dbgsel untouched
        vc0 = valid_cycles;
        exp_done.push_back(1'b1);
        go(8'd10, 8'd9);
        wait_done("t3_done", 20);
        chk("t3_no_records", 32'(valid_cycles - vc0), 32'd0);
        chk("t3_dbgsel_kept", 32'(dbgsel), 32'd65);

        // 254..255 ends without wrapping; a start while busy is ignored
        push_rec(8'd254, 8'h00); push_rec(8'd255, 8'h00);
        exp_done.push_back(1'b0);
        go(8'd254, 8'd255);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; start_sel = 8'd0; end_sel = 8'd0;
        @(posedge clk); #1 start = 1'b0;
        wait_done("t4_done", 100);
        repeat (6) @(negedge clk);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_dbgsel_last", 32'(dbgsel), 32'd255);

        // 0..100 aborted in the WAIT of select 5
        n0 = done_count;
        for (int s = 0; s < 5; s++) push_rec(8'(s), 8'h00);
        go(8'd0, 8'd100);
        seen5 = 1'b0;
        for (int i = 0; i < 200 && !seen5; i++) begin
            @(negedge clk);
            if (dbgsel == 8'd5) seen5 = 1'b1;
        end
        chk("t5_reach_sel5", 32'(seen5), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_valid", 32'(rec_if.out_valid), 32'd0);
        chk("t5_abort_dbgsel", 32'(dbgsel), 32'd5);
        repeat (10) @(posedge clk);
        chk("t5_no_done", 32'(done_count - n0), 32'd0);
        push_rec(8'd40, 8'hA5);
        exp_done.push_back(1'b0);
        go(8'd40, 8'd40);
        wait_done("t5_restart_done", 50);

        // Reset for one cycle with a record pending
        rec_if.out_ready = 1'b0;
        n0 = done_count;
        go(8'd50, 8'd60);
        wait_valid("t6_pending", 50);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("t6_rst");
        chk("t6_no_done", 32'(done_count - n0), 32'd0);
        rec_if.out_ready = 1'b1;
        push_rec(8'd34, 8'hA5);
        exp_done.push_back(1'b0);
        go(8'd34, 8'd34);
        wait_done("t6_restart_done", 50);

        repeat (4) @(posedge clk);
        chk("leftover_records", 32'(exp_rec.size()), 32'd0);
        chk("leftover_done", 32'(exp_done.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_sel_sweeper.md
Name: dbg_sel_sweeper

Overview:
- Initiator end of the debug-select bus: drives `dbgsel` into the registered debug-mux tree and samples the returned OR-combined debug data.
- Sweeps an inclusive select range and returns one (select, data) record per select over a valid/ready stream.
- Sits beside the debug tree, driving the same `dbgsel` net that software or a port drove before.
- Compensates for the tree's fixed register latency, so every captured sample matches the select that produced it.

Parameters:
- SEL_W, 8: width of debug select.
- DATA_W, 8: width of debug data.
- LATENCY, 2: rising edges from a `dbgsel` change to valid `din`. Must be >= 1; elaboration error otherwise.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- abort  in  1  terminate the sweep at once; no done pulse
- start_sel  in  SEL_W  first select (inclusive), sampled with start
- end_sel  in  SEL_W  last select (inclusive), sampled with start
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- dbgsel  out  SEL_W  registered select driven to the debug tree
- din  in  DATA_W  debug data returned by the tree
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts the record
- out_sel  out  SEL_W  select of the current record
- out_data  out  DATA_W  captured data of the current record
- done  out  1  one-cycle pulse when a sweep completes normally
- err  out  1  one-cycle pulse, coincident with done, when start_sel > end_sel

Behaviour:
- Reset values: all outputs 0 (busy, dbgsel, out_valid, out_sel, out_data, done, err); state IDLE; counters 0.
- Reset mid-sweep returns to IDLE on the next edge. Any pending record is discarded.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE:
  - On start with start_sel <= end_sel: cur <= start_sel, last <= end_sel, go to ISSUE.
  - On start with start_sel > end_sel: go to FINISH with err flagged; no records.
  - dbgsel holds its last value.
- ISSUE, one cycle: dbgsel <= cur, wcnt <= 0, go to WAIT.
- WAIT:
  - wcnt increments each cycle.
  - At the LATENCY-th edge after the edge that loaded dbgsel: out_data <= din, out_sel <= cur, out_valid <= 1, go to PRESENT.
  - With LATENCY=2, din is sampled on the cycle starting 2 edges after the dbgsel update.
- PRESENT:
  - out_valid, out_sel and out_data stay stable until out_ready.
  - On out_valid && out_ready: out_valid <= 0.
  - If cur == last, go to FINISH; else cur <= cur+1 and go to ISSUE.
  - The equality check precedes the increment, so end_sel = all-ones never wraps and a full 2^SEL_W sweep is legal.
- FINISH, one cycle: done <= 1 (err <= 1 if flagged), busy <= 0, go to IDLE.
- Throughput: one record every LATENCY+2 cycles when out_ready is held high.
- abort in any non-IDLE state: IDLE next edge, out_valid <= 0, busy <= 0, no done; dbgsel holds. abort has priority over out_ready in the same cycle (record dropped).
- start while busy: ignored, no effect.
- start and abort in the same IDLE cycle: abort wins, sweep not started.

Decomposition:
- Shared package dbg_pkg:
  - state enum typedef dbg_sweep_state_t;
  - default widths DBG_SEL_W=8 and DBG_DATA_W=8;
  - DBG_TREE_LATENCY=2, so instantiations and the debug tree agree.
- One sub-module, dbg_sample_delay: a LATENCY-deep wait counter with a capture strobe.
- FSM and output register live in dbg_sel_sweeper.

Test Plan:
- Bench model: 2-stage registered tree returning dval=8'hA5 for dbgsel in 34..64, else 0.
- Sweep 33..35, out_ready=1: records (33,00), (34,A5), (35,A5), each 4 cycles apart, then done=1 for one cycle, busy falls with done.
- Sweep 64..65, out_ready low for 5 cycles on the first record: (64,A5) held stable with out_valid=1 all 5 cycles, then (65,00), done.
- start_sel=10, end_sel=9: no out_valid; done=1 and err=1 together in one cycle; dbgsel unchanged.
- Sweep 254..255: records for 254 and 255 only, no wrap to 0; second start issued during the sweep is ignored.
- Sweep 0..100, abort asserted during WAIT of select 5: out_valid never set for 5, busy=0 next cycle, no done. A new start 40..40 then yields the single record (40,A5).
- rst=1 for one cycle mid-sweep: all outputs 0 next cycle, no done; a subsequent start behaves normally.
